seq_trigger_unit: RTL and testbench

Parametrised, multi-stage successor to the logic-analyzer trigger unit. It evaluates NUM_CH synchronised channel samples, plus the protocol-trigger flag, against a per-stage configuration, and advances through up to NUM_STAGES sequential stages. Each stage carries its own occurrence count. `triggered` asserts when the final stage completes. It sits between the channel sample front end and the capture controller, which observes `triggered` and returns `capture_done`.

---
 rtl/trig_pkg.sv | 23 ++
 rtl/chan_event_det.sv | 43 ++++
 rtl/seq_trigger_unit.sv | 148 ++++++++++++++
 tb/tb_seq_trigger_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared constants for the sequential trigger unit: channel mode codes,
// event-vector bit positions and the sequencer state encoding.
package trig_pkg;

  localparam logic [2:0] CH_OFF  = 3'd0;
  localparam logic [2:0] CH_RISE = 3'd1;
  localparam logic [2:0] CH_FALL = 3'd2;
  localparam logic [2:0] CH_HIGH = 3'd3;
  localparam logic [2:0] CH_LOW  = 3'd4;

  // Bit positions inside the per-channel {low, high, fall, rise} vector
  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_HIGH = 2;
  localparam int EV_LOW  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEQ  = 2'd1,
    TRIG = 2'd2
  } state_t;

endpackage

// File: rtl/chan_event_det.sv
// Per-channel event detector: keeps the previous-cycle comparator samples and
// produces level and edge terms, with edges suppressed on the first armed cycle.
module chan_event_det (
  input  logic       clk,
  input  logic       rst,
  input  logic       ch_hi,
  input  logic       ch_lo,
  input  logic       armed,
  output logic [3:0] ev
);
  import trig_pkg::*;

  logic hi_q, hi_d;
  logic lo_q, lo_d;
  logic armed_q, armed_d;

  always_comb begin
    hi_d    = ch_hi;
    lo_d    = ch_lo;
    armed_d = armed;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    ev          = 4'b0000;
    ev[EV_RISE] = ch_hi & ~hi_q & armed_q;
    ev[EV_FALL] = ~ch_lo & lo_q & armed_q;
    ev[EV_HIGH] = ch_hi;
    ev[EV_LOW]  = ~ch_lo;
  end

endmodule

// File: rtl/seq_trigger_unit.sv
// Multi-stage logic-analyzer trigger: each stage ANDs its channel terms (and
// optionally the protocol flag) and must match stage_count times to advance.
module seq_trigger_unit #(
  parameter int NUM_CH     = 5,
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 16,
  localparam int SW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              ch_hi,
  input  logic [NUM_CH-1:0]              ch_lo,
  input  logic                           prot_trig,
  input  logic [NUM_STAGES*NUM_CH*3-1:0] stage_mode,
  input  logic [NUM_STAGES-1:0]          stage_prot_en,
  input  logic [NUM_STAGES*CNT_W-1:0]    stage_count,
  input  logic [SW-1:0]                  last_stage,
  input  logic                           armed,
  input  logic                           capture_done,
  output logic                           triggered,
  output logic [SW-1:0]                  cur_stage
);
  import trig_pkg::*;

  localparam logic [SW-1:0] MAX_STAGE = SW'(NUM_STAGES - 1);

  state_t            state_q, state_d;
  logic [SW-1:0]     cur_stage_q, cur_stage_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              triggered_q, triggered_d;

  logic [NUM_CH*4-1:0] ev;
  logic [NUM_CH-1:0]   term;
  logic [NUM_CH-1:0]   active;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [2:0] ch_mode;
      logic       ch_term;
      logic       ch_active;

      chan_event_det u_det (
        .clk   (clk),
        .rst   (rst),
        .ch_hi (ch_hi[gi]),
        .ch_lo (ch_lo[gi]),
        .armed (armed),
        .ev    (ev[gi*4 +: 4])
      );

      // Inactive channels contribute a 1 so they drop out of the AND
      always_comb begin
        ch_mode   = stage_mode[(int'(cur_stage_q)*NUM_CH + gi)*3 +: 3];
        ch_term   = 1'b1;
        ch_active = 1'b1;
        case (ch_mode)
          CH_RISE: ch_term = ev[gi*4 + EV_RISE];
          CH_FALL: ch_term = ev[gi*4 + EV_FALL];
          CH_HIGH: ch_term = ev[gi*4 + EV_HIGH];
          CH_LOW:  ch_term = ev[gi*4 + EV_LOW];
          default: ch_active = 1'b0;
        endcase
      end

      assign term[gi]   = ch_term;
      assign active[gi] = ch_active;
    end
  endgenerate

  logic             prot_en;
  logic             stage_match;
  logic [CNT_W-1:0] cnt_sel;
  logic [CNT_W-1:0] cnt_eff;
  logic [CNT_W:0]   occ_inc;
  logic             stage_done;
  logic [SW-1:0]    last_eff;

  always_comb begin
    prot_en     = stage_prot_en[cur_stage_q];
    // A stage with nothing enabled must never match
    stage_match = (&term) & (~prot_en | prot_trig) & ((|active) | prot_en);
    cnt_sel     = stage_count[int'(cur_stage_q)*CNT_W +: CNT_W];
    cnt_eff     = (cnt_sel == '0) ? CNT_W'(1) : cnt_sel;
    occ_inc     = {1'b0, occ_q} + {{CNT_W{1'b0}}, 1'b1};
    stage_done  = occ_inc >= {1'b0, cnt_eff};
    last_eff    = (last_stage > MAX_STAGE) ? MAX_STAGE : last_stage;
  end

  always_comb begin
    state_d     = state_q;
    cur_stage_d = cur_stage_q;
    occ_d       = occ_q;
    case (state_q)
      IDLE: begin
        cur_stage_d = '0;
        occ_d       = '0;
        if (armed) state_d = SEQ;
      end
      SEQ: begin
        if (!armed) begin
          state_d     = IDLE;
          cur_stage_d = '0;
          occ_d       = '0;
        end else if (stage_match) begin
          if (stage_done) begin
            occ_d = '0;
            if (cur_stage_q == last_eff) state_d = TRIG;
            else                         cur_stage_d = cur_stage_q + 1'b1;
          end else if (!(&occ_q)) begin
            occ_d = occ_inc[CNT_W-1:0];
          end
        end
      end
      TRIG: begin
        if (capture_done) begin
          state_d     = IDLE;
          cur_stage_d = '0;
          occ_d       = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        cur_stage_d = '0;
        occ_d       = '0;
      end
    endcase
    triggered_d = (state_d == TRIG);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_stage_q <= '0;
      occ_q       <= '0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_stage_q <= cur_stage_d;
      occ_q       <= occ_d;
      triggered_q <= triggered_d;
    end
  end

  assign triggered = triggered_q;
  assign cur_stage = cur_stage_q;

endmodule

// File: tb/tb_seq_trigger_unit.sv
// Directed bench for seq_trigger_unit: single/two-stage sequences, level counts,
// arming corner cases, empty stage and asynchronous reset.
module tb_seq_trigger_unit;

  localparam int NUM_CH     = 5;
  localparam int NUM_STAGES = 4;
  localparam int CNT_W      = 16;
  localparam int SW         = 2;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [NUM_CH-1:0]              ch_hi;
  logic [NUM_CH-1:0]              ch_lo;
  logic                           prot_trig;
  logic [NUM_STAGES*NUM_CH*3-1:0] stage_mode;
  logic [NUM_STAGES-1:0]          stage_prot_en;
  logic [NUM_STAGES*CNT_W-1:0]    stage_count;
  logic [SW-1:0]                  last_stage;
  logic                           armed;
  logic                           capture_done;
  logic                           triggered;
  logic [SW-1:0]                  cur_stage;

  int checks = 0;
  int errors = 0;

  seq_trigger_unit #(
    .NUM_CH     (NUM_CH),
    .NUM_STAGES (NUM_STAGES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ch_hi         (ch_hi),
    .ch_lo         (ch_lo),
    .prot_trig     (prot_trig),
    .stage_mode    (stage_mode),
    .stage_prot_en (stage_prot_en),
    .stage_count   (stage_count),
    .last_stage    (last_stage),
    .armed         (armed),
    .capture_done  (capture_done),
    .triggered     (triggered),
    .cur_stage     (cur_stage)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_mode(input int s, input int c, input logic [2:0] m);
    stage_mode[(s*NUM_CH + c)*3 +: 3] = m;
  endtask

  task automatic set_count(input int s, input logic [CNT_W-1:0] v);
    stage_count[s*CNT_W +: CNT_W] = v;
  endtask

  task automatic clear_all();
    armed         = 1'b0;
    capture_done  = 1'b0;
    ch_hi         = '0;
    ch_lo         = '1;
    prot_trig     = 1'b0;
    stage_mode    = '0;
    stage_prot_en = '0;
    stage_count   = '0;
    last_stage    = '0;
    ticks(3);
  endtask

  task automatic release_trig();
    capture_done = 1'b1;
    tick();
    capture_done = 1'b0;
    armed        = 1'b0;
    ticks(2);
  endtask

  initial begin
    int held;
    int hits;
    rst = 1'b1;
    armed = 1'b0; capture_done = 1'b0; ch_hi = '0; ch_lo = '1; prot_trig = 1'b0;
    stage_mode = '0; stage_prot_en = '0; stage_count = '0; last_stage = '0;
    ticks(2);
    check("reset_trig", {31'd0, triggered}, 32'd0);
    check("reset_stage", {30'd0, cur_stage}, 32'd0);
    rst = 1'b0;
    clear_all();

    // Single stage, CH0 rise
    set_mode(0, 0, 3'd1); set_count(0, 16'd1); last_stage = 2'd0;
    armed = 1'b1;
    ticks(3);
    check("single_pre", {31'd0, triggered}, 32'd0);
    ch_hi[0] = 1'b1;
    tick();
    check("single_trig", {31'd0, triggered}, 32'd1);
    ch_hi[0] = 1'b0;
    held = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (triggered === 1'b1) held++;
    end
    check("single_hold", held, 32'd20);
    capture_done = 1'b1;
    tick();
    capture_done = 1'b0;
    check("single_release", {31'd0, triggered}, 32'd0);
    tick();
    check("single_rearm_quiet", {31'd0, triggered}, 32'd0);
    armed = 1'b0;
    clear_all();

    // Two stages: CH1 fall x3, then CH2 high with prot
    set_mode(0, 1, 3'd2); set_count(0, 16'd3);
    set_mode(1, 2, 3'd3); set_count(1, 16'd1); stage_prot_en[1] = 1'b1;
    last_stage = 2'd1;
    armed = 1'b1;
    ticks(3);
    for (int f = 0; f < 3; f++) begin
      ch_lo[1] = 1'b0; tick();
      ch_lo[1] = 1'b1; tick();
      if (f == 1) check("two_after2", {30'd0, cur_stage}, 32'd0);
    end
    check("two_after3", {30'd0, cur_stage}, 32'd1);
    ch_hi[2] = 1'b1;
    tick();
    check("two_noprot", {31'd0, triggered}, 32'd0);
    prot_trig = 1'b1;
    tick();
    prot_trig = 1'b0;
    check("two_trig", {31'd0, triggered}, 32'd1);
    release_trig();
    clear_all();

    // Level count: CH3 high, count 5
    set_mode(0, 3, 3'd3); set_count(0, 16'd5);
    armed = 1'b1;
    ticks(3);
    ch_hi[3] = 1'b1; ticks(4);
    ch_hi[3] = 1'b0; ticks(3);
    check("level_4", {31'd0, triggered}, 32'd0);
    ch_hi[3] = 1'b1; tick();
    ch_hi[3] = 1'b0;
    check("level_5", {31'd0, triggered}, 32'd1);
    release_trig();
    set_count(0, 16'd0);
    armed = 1'b1;
    ticks(3);
    ch_hi[3] = 1'b1; tick();
    ch_hi[3] = 1'b0;
    check("level_cnt0", {31'd0, triggered}, 32'd1);
    release_trig();
    clear_all();

    // Undefined mode code acts as OFF
    set_mode(0, 0, 3'd5); set_mode(0, 1, 3'd3); set_count(0, 16'd1);
    armed = 1'b1;
    ticks(3);
    ch_hi[1] = 1'b1; tick();
    ch_hi[1] = 1'b0;
    check("mode5_off", {31'd0, triggered}, 32'd1);
    release_trig();
    clear_all();

    // Edge on the first armed cycle is not counted
    set_mode(0, 0, 3'd1); set_count(0, 16'd1);
    armed = 1'b1; ch_hi[0] = 1'b1;
    ticks(4);
    check("arm_edge", {31'd0, triggered}, 32'd0);
    clear_all();

    // Disarm at stage 1 together with a matching sample
    set_mode(0, 0, 3'd3); set_count(0, 16'd1);
    set_mode(1, 1, 3'd3); set_count(1, 16'd1);
    last_stage = 2'd1;
    armed = 1'b1;
    ticks(3);
    ch_hi[0] = 1'b1; tick();
    ch_hi[0] = 1'b0;
    check("disarm_s1", {30'd0, cur_stage}, 32'd1);
    ch_hi[1] = 1'b1; armed = 1'b0;
    tick();
    check("disarm_stage", {30'd0, cur_stage}, 32'd0);
    check("disarm_trig", {31'd0, triggered}, 32'd0);
    tick();
    check("disarm_trig2", {31'd0, triggered}, 32'd0);
    clear_all();

    // Empty stage with every input toggling
    armed = 1'b1;
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      ch_hi     = NUM_CH'($urandom);
      ch_lo     = NUM_CH'($urandom);
      prot_trig = 1'(($urandom >> 3) & 1);
      tick();
      if (triggered !== 1'b0) hits++;
    end
    check("empty_stage", hits, 32'd0);
    clear_all();

    // Asynchronous reset at stage 2
    set_mode(0, 0, 3'd3); set_count(0, 16'd1);
    set_mode(1, 1, 3'd3); set_count(1, 16'd1);
    set_mode(2, 2, 3'd3); set_count(2, 16'd1);
    set_mode(3, 4, 3'd3); set_count(3, 16'd1);
    last_stage = 2'd3;
    armed = 1'b1;
    ticks(3);
    ch_hi = 5'b00001; tick();
    ch_hi = 5'b00010; tick();
    ch_hi = 5'b00000;
    check("rst_s2", {30'd0, cur_stage}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("rst_async_stage", {30'd0, cur_stage}, 32'd0);
    check("rst_async_trig", {31'd0, triggered}, 32'd0);
    tick();
    rst = 1'b0;
    armed = 1'b0;
    ch_hi = 5'b11111;
    ticks(5);
    check("rst_no_rearm", {31'd0, triggered}, 32'd0);
    ch_hi = 5'b00000;
    clear_all();

    // Asynchronous reset while triggered
    set_mode(0, 0, 3'd3); set_count(0, 16'd1);
    armed = 1'b1;
    ticks(3);
    ch_hi[0] = 1'b1; tick();
    ch_hi[0] = 1'b0;
    check("rst_trig_pre", {31'd0, triggered}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_trig_drop", {31'd0, triggered}, 32'd0);
    tick();
    rst = 1'b0;
    clear_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
